// File: rtl/frame_gray_pipeline.sv
// Single-frame capture-and-convert pipeline: buffers one packed RGB frame, then streams 8-bit gray samples.
// Optional build macro WEIGHTED_GRAY_EN selects BT.601-style weights instead of (R+2G+B)>>2.
module frame_gray_pipeline #(
  parameter int unsigned DEPTH  = 96,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       clear,
  input  logic       cam_valid,
  input  logic [7:0] cam_data,
  input  logic       gray_ready,
  output logic       cam_enable,
  output logic [7:0] gray_data,
  output logic       gray_valid,
  output logic       busy,
  output logic       capture_done,
  output logic       frame_done
);

  typedef enum logic [1:0] {IDLE, CAPTURE, PROCESS} state_t;

  localparam int unsigned PIX = DEPTH / 3;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(PIX - 1);

  state_t state, next_state;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, pix_cnt;
  logic              rd_done, rd_valid;
  logic [7:0]        rd_data;
  logic [1:0]        byte_cnt;
  logic [7:0]        r_q, g_q;
  logic [7:0]        skid_data;
  logic              skid_valid;
  logic [7:0]        gray_new;

  logic wr_en, wr_last, pause, rd_issue, accept, last_accept, pix_done;

  assign wr_en       = (state == CAPTURE) && cam_valid && !clear;
  assign wr_last     = wr_en && (wr_ptr == LAST_ADDR);
  assign pause       = gray_valid && !gray_ready;
  assign rd_issue    = (state == PROCESS) && !rd_done && !pause && !clear;
  assign accept      = gray_valid && gray_ready;
  assign last_accept = (state == PROCESS) && accept && (pix_cnt == LAST_PIX);
  assign pix_done    = rd_valid && (byte_cnt == 2'd2);

  assign cam_enable = (state == CAPTURE);
  assign busy       = (state != IDLE);

`ifdef WEIGHTED_GRAY_EN
  logic [15:0] gray_sum;
  always_comb begin
    gray_sum = 16'(r_q) * 16'd77 + 16'(g_q) * 16'd150 + 16'(rd_data) * 16'd29;
    gray_new = gray_sum[15:8];
  end
`else
  logic [9:0] gray_sum;
  always_comb begin
    gray_sum = {2'b00, r_q} + {1'b0, g_q, 1'b0} + {2'b00, rd_data};
    gray_new = gray_sum[9:2];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (start)       next_state = CAPTURE;
        CAPTURE: if (wr_last)     next_state = PROCESS;
        PROCESS: if (last_accept) next_state = IDLE;
        default:                  next_state = IDLE;
      endcase
    end
  end

  // Buffer RAM: never reset, synchronous read with one cycle latency.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= cam_data;
    rd_data <= mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      pix_cnt      <= '0;
      rd_done      <= 1'b0;
      rd_valid     <= 1'b0;
      byte_cnt     <= '0;
      r_q          <= '0;
      g_q          <= '0;
      skid_data    <= '0;
      skid_valid   <= 1'b0;
      gray_data    <= '0;
      gray_valid   <= 1'b0;
      capture_done <= 1'b0;
      frame_done   <= 1'b0;
    end else if (clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      pix_cnt      <= '0;
      rd_done      <= 1'b0;
      rd_valid     <= 1'b0;
      byte_cnt     <= '0;
      skid_valid   <= 1'b0;
      gray_data    <= '0;
      gray_valid   <= 1'b0;
      capture_done <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      capture_done <= wr_last;
      frame_done   <= last_accept;

      if (wr_en) wr_ptr <= wr_last ? '0 : wr_ptr + 1'b1;

      rd_valid <= rd_issue;
      if (rd_issue) begin
        rd_ptr  <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
        rd_done <= (rd_ptr == LAST_ADDR);
      end
      if (last_accept) rd_done <= 1'b0;

      // Bytes already in flight are always absorbed, even while paused.
      if (rd_valid) begin
        case (byte_cnt)
          2'd0:    begin r_q <= rd_data; byte_cnt <= 2'd1; end
          2'd1:    begin g_q <= rd_data; byte_cnt <= 2'd2; end
          default: byte_cnt <= 2'd0;
        endcase
      end

      // Output register with one-entry skid for a pixel that completes while the output is held.
      if (accept) begin
        pix_cnt <= (pix_cnt == LAST_PIX) ? '0 : pix_cnt + 1'b1;
        if (skid_valid) begin
          gray_data  <= skid_data;
          skid_valid <= pix_done;
          if (pix_done) skid_data <= gray_new;
        end else if (pix_done) begin
          gray_data <= gray_new;
        end else begin
          gray_valid <= 1'b0;
        end
      end else if (pix_done) begin
        if (gray_valid) begin
          skid_data  <= gray_new;
          skid_valid <= 1'b1;
        end else begin
          gray_data  <= gray_new;
          gray_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_gray_pipeline.sv
// Directed self-checking bench for frame_gray_pipeline (DEPTH=96), valid with or without WEIGHTED_GRAY_EN.
module tb_frame_gray_pipeline;

  localparam int unsigned DEPTH = 96;
  localparam int unsigned NPIX  = DEPTH / 3;

  logic       clk = 1'b0;
  logic       rst, start, clear, cam_valid, gray_ready;
  logic [7:0] cam_data;
  logic       cam_enable, gray_valid, busy, capture_done, frame_done;
  logic [7:0] gray_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] frame [DEPTH];
  logic [7:0] expv  [NPIX];
  logic [7:0] got   [$];

  always #5 clk = ~clk;

  frame_gray_pipeline #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .cam_valid(cam_valid), .cam_data(cam_data), .gray_ready(gray_ready),
    .cam_enable(cam_enable), .gray_data(gray_data), .gray_valid(gray_valid),
    .busy(busy), .capture_done(capture_done), .frame_done(frame_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gray_ref(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
`ifdef WEIGHTED_GRAY_EN
    logic [15:0] s;
    s = 16'(r) * 16'd77 + 16'(g) * 16'd150 + 16'(b) * 16'd29;
    return s[15:8];
`else
    logic [9:0] s;
    s = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return s[9:2];
`endif
  endfunction

  task automatic set_pixel(input int i, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    frame[3*i] = r; frame[3*i+1] = g; frame[3*i+2] = b;
  endtask

  task automatic feed(input bit gapped, input string tag);
    int early = 0;
    for (int k = 0; k < DEPTH; k++) begin
      cam_valid = 1'b1;
      cam_data  = frame[k];
      tick;
      if (k != DEPTH - 1) begin
        if (capture_done) early++;
        if (gapped) begin
          cam_valid = 1'b0;
          cam_data  = 8'hA5;
          tick;
          if (capture_done) early++;
        end
      end
    end
    cam_valid = 1'b0;
    chk({tag, "_capture_early"}, early, 0);
    chk({tag, "_capture_done"}, capture_done, 1);
    chk({tag, "_cam_enable_off"}, cam_enable, 0);
    chk({tag, "_busy_in_process"}, busy, 1);
  endtask

  // Starts in the first PROCESS cycle; returns once frame_done is seen or the budget runs out.
  task automatic collect(input bit bp, output int first_cyc, output int spacing_bad,
                         output int unstable, output int done_seen);
    int last_cyc = -1;
    bit bp_done  = 1'b0;
    logic [7:0] held;
    got.delete();
    first_cyc = -1; spacing_bad = 0; unstable = 0; done_seen = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (frame_done) begin
        done_seen = 1;
        break;
      end
      gray_ready = 1'b1;
      if (bp && !bp_done && gray_valid && got.size() == 3) begin
        held       = gray_data;
        gray_ready = 1'b0;
        for (int h = 0; h < 10; h++) begin
          tick;
          if (!gray_valid || gray_data !== held) unstable++;
        end
        bp_done    = 1'b1;
        gray_ready = 1'b1;
      end
      if (gray_valid && gray_ready) begin
        got.push_back(gray_data);
        if (first_cyc < 0) first_cyc = cyc;
        if (last_cyc >= 0 && cyc - last_cyc != 3) spacing_bad++;
        last_cyc = cyc;
      end
      tick;
    end
  endtask

  initial begin
    int first_cyc, spacing_bad, unstable, done_seen, bad, cnt;

    rst = 1'b1; start = 1'b0; clear = 1'b0; cam_valid = 1'b0; cam_data = '0; gray_ready = 1'b1;
    repeat (150) tick;
    rst = 1'b0;
    chk("rst_cam_enable", cam_enable, 0);
    chk("rst_gray_valid", gray_valid, 0);
    chk("rst_gray_data", gray_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_capture_done", capture_done, 0);
    chk("rst_frame_done", frame_done, 0);
    tick;
    chk("idle_busy", busy, 0);

    // Frame 1: all-white, continuous input, gray_ready held high.
    for (int i = 0; i < NPIX; i++) set_pixel(i, 8'd255, 8'd255, 8'd255);
    start = 1'b1; tick; start = 1'b0;
    chk("start_cam_enable", cam_enable, 1);
    chk("start_busy", busy, 1);
    feed(1'b0, "f1");
    collect(1'b0, first_cyc, spacing_bad, unstable, done_seen);
    chk("f1_first_latency", first_cyc, 4);
    chk("f1_spacing_bad", spacing_bad, 0);
    chk("f1_count", got.size(), NPIX);
    bad = 0;
    foreach (got[i]) if (got[i] !== 8'd255) bad++;
    chk("f1_white_bad", bad, 0);
    chk("f1_frame_done", done_seen, 1);
    chk("f1_busy_at_done", busy, 0);
    tick;
    chk("f1_done_one_cycle", frame_done, 0);

    // Frame 2: primaries then mixed pixels, gapped input, backpressure, stray bytes during PROCESS.
    set_pixel(0, 8'd255, 8'd0, 8'd0);
    set_pixel(1, 8'd0, 8'd255, 8'd0);
    set_pixel(2, 8'd0, 8'd0, 8'd255);
`ifdef WEIGHTED_GRAY_EN
    expv[0] = 8'd76; expv[1] = 8'd149; expv[2] = 8'd28;
`else
    expv[0] = 8'd63; expv[1] = 8'd127; expv[2] = 8'd63;
`endif
    for (int i = 3; i < NPIX; i++) begin
      set_pixel(i, 8'(i * 8), 8'(255 - i * 5), 8'(i * 3 + 10));
      expv[i] = gray_ref(8'(i * 8), 8'(255 - i * 5), 8'(i * 3 + 10));
    end
    start = 1'b1; tick; start = 1'b0;
    feed(1'b1, "f2");
    cam_valid = 1'b1; cam_data = 8'h11;
    collect(1'b1, first_cyc, spacing_bad, unstable, done_seen);
    cam_valid = 1'b0;
    chk("f2_bp_stable", unstable, 0);
    chk("f2_count", got.size(), NPIX);
    cnt = (got.size() < NPIX) ? got.size() : NPIX;
    chk("f2_px0", (cnt > 0) ? got[0] : 32'hFFFF, expv[0]);
    chk("f2_px1", (cnt > 1) ? got[1] : 32'hFFFF, expv[1]);
    chk("f2_px2", (cnt > 2) ? got[2] : 32'hFFFF, expv[2]);
    bad = 0;
    for (int i = 0; i < cnt; i++) if (got[i] !== expv[i]) bad++;
    chk("f2_sequence_bad", bad, 0);
    chk("f2_frame_done", done_seen, 1);
    // A new start is taken in the frame_done cycle.
    start = 1'b1; tick; start = 1'b0;
    chk("f3_start_on_done", busy, 1);
    chk("f3_cam_enable", cam_enable, 1);

    // Frame 3: abort mid-PROCESS with an output held.
    feed(1'b0, "f3");
    gray_ready = 1'b1;
    cnt = 0;
    while (!gray_valid && cnt < 50) begin tick; cnt++; end
    chk("f3_valid_seen", gray_valid, 1);
    gray_ready = 1'b0;
    tick;
    clear = 1'b1; tick; clear = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_gray_valid", gray_valid, 0);
    chk("abort_cam_enable", cam_enable, 0);
    gray_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 120; i++) begin
      tick;
      if (frame_done || gray_valid || busy) bad++;
    end
    chk("abort_quiet", bad, 0);

    // start together with clear in IDLE is ignored.
    start = 1'b1; clear = 1'b1; tick; start = 1'b0; clear = 1'b0;
    chk("start_clear_busy", busy, 0);
    chk("start_clear_cam_enable", cam_enable, 0);

    // Frame 4: clean frame after abort.
    for (int i = 0; i < NPIX; i++) set_pixel(i, 8'd255, 8'd255, 8'd255);
    start = 1'b1; tick; start = 1'b0;
    feed(1'b0, "f4");
    collect(1'b0, first_cyc, spacing_bad, unstable, done_seen);
    chk("f4_count", got.size(), NPIX);
    bad = 0;
    foreach (got[i]) if (got[i] !== 8'd255) bad++;
    chk("f4_white_bad", bad, 0);
    chk("f4_frame_done", done_seen, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
